// File: rtl/parity_pkg.sv
// Purpose: shared types and helpers for the parity serial transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Level driven on the line between frames and during the stop bit.
  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Widest payload calc_parity accepts. Callers zero-extend into it; the
  // padding zeros leave the XOR reduction unchanged.
  localparam int PARITY_MAX_W = 64;

  // Even parity when odd == 0, odd parity when odd == 1.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_baud_tick.sv
// Purpose: bit-period counter; tick marks the last clk cycle of each serial bit.
// Latency: tick is combinational from the count register (same cycle).
// Backpressure: none; clear holds the count at 0 for as long as it is high.
//
// Ports:
//   clk, reset_n : clock and async active-low reset
//   clear        : force the count back to 0 on the next edge
//   tick         : high while count == CLKS_PER_BIT-1; count reloads 0 after it
module parity_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/parity_serial_tx.sv
// Purpose: accept a word over valid/ready and serialise start+data(LSB first)+parity+stop.
// Latency: first start-bit cycle follows accept; frame is (DATA_W+3)*CLKS_PER_BIT cycles.
// Backpressure: data_ready is high only in IDLE; data_valid elsewhere is ignored.
//
// Ports:
//   clk, reset_n : clock and async active-low reset (frame in flight is dropped)
//   data_in      : word to send, sampled on accept (data_valid && data_ready)
//   data_valid   : producer has data_in valid
//   data_ready   : block idle and able to accept
//   tx_out       : registered serial line, idle high
//   tx_busy      : high from the cycle after accept through the last stop cycle
//   frame_done   : one-cycle pulse on the last stop-bit cycle
//
// Build option: define PARITY_TX_ODD_EN for odd parity (default is even).
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

`ifdef PARITY_TX_ODD_EN
  localparam logic PARITY_ODD = 1'b1;
`else
  localparam logic PARITY_ODD = 1'b0;
`endif

  tx_state_t         state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              accept;
  logic              baud_clr;
  logic              baud_tick;

  parity_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clr),
    .tick    (baud_tick)
  );

  assign accept = data_valid && data_ready;
  assign tx_out = tx_q;

  // State register. tx_q is loaded from the level the line must carry in the
  // upcoming cycle, so the pad sees a flop output with no extra cycle of lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      tx_q      <= TX_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic. Every bit boundary coincides with baud_tick, and the
  // baud counter reloads on tick, so it restarts at 0 for each new bit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          bit_cnt_d = '0;
          data_d    = data_in;
          parity_d  = calc_parity(PARITY_MAX_W'(data_in), PARITY_ODD);
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. Handshake/status decode from the current state; the line level
  // is decoded from the next state so tx_q lines up with state_q.
  always_comb begin
    data_ready = (state_q == IDLE);
    tx_busy    = (state_q != IDLE);
    frame_done = (state_q == STOP) && baud_tick;
    baud_clr   = (state_q == IDLE);
    tx_d       = TX_IDLE_LEVEL;
    case (state_d)
      IDLE:    tx_d = TX_IDLE_LEVEL;
      START:   tx_d = ~TX_IDLE_LEVEL;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = parity_d;
      STOP:    tx_d = TX_IDLE_LEVEL;
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Purpose: directed self-checking bench for parity_serial_tx.
// Latency: n/a.
// Backpressure: n/a.
//
// Instance dut_a: DATA_W=8, CLKS_PER_BIT=4. Instance dut_b: DATA_W=5, CLKS_PER_BIT=2.
// Build option PARITY_TX_ODD_EN flips the expected parity bits.
module tb_parity_serial_tx;

`ifdef PARITY_TX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  // Hand-counted parity: A5,3C,C3,96 have four ones; 01 has one; 5'h1F has five.
  localparam logic PAR_A5 = ODD ? 1'b1 : 1'b0;
  localparam logic PAR_01 = ODD ? 1'b0 : 1'b1;
  localparam logic PAR_3C = ODD ? 1'b1 : 1'b0;
  localparam logic PAR_C3 = ODD ? 1'b1 : 1'b0;
  localparam logic PAR_96 = ODD ? 1'b1 : 1'b0;
  localparam logic PAR_1F = ODD ? 1'b0 : 1'b1;

  logic       clk;
  logic       reset_n;
  logic [7:0] data_a;
  logic       valid_a, ready_a, tx_a, busy_a, done_a;
  logic [4:0] data_b;
  logic       valid_b, ready_b, tx_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .tx_out     (tx_a),
    .tx_busy    (busy_a),
    .frame_done (done_a)
  );

  parity_serial_tx #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .tx_out     (tx_b),
    .tx_busy    (busy_b),
    .frame_done (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for each of the 44 cycles of an 8-bit frame at 4 clk/bit.
  // Bit 0 is the first START cycle.
  function automatic logic [43:0] exp_wave(input logic [7:0] d, input logic p);
    logic [10:0] slots;
    logic [43:0] w;
    slots = {1'b1, p, d, 1'b0};
    for (int i = 0; i < 44; i++) w[i] = slots[i/4];
    return w;
  endfunction

  // Samples 44 cycles starting with the cycle after the accept edge.
  task automatic capture_a(output logic [43:0] wave, output int done_cyc,
                           output int done_cnt, output int busy_cnt, output int rdy_low);
    wave = '0; done_cyc = 0; done_cnt = 0; busy_cnt = 0; rdy_low = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      wave[c] = tx_a;
      if (done_a)   begin done_cnt++; done_cyc = c + 1; end
      if (busy_a)   busy_cnt++;
      if (!ready_a) rdy_low++;
    end
  endtask

  task automatic send_a(input string tag, input logic [7:0] d);
    @(negedge clk);
    check({tag, "_ready_pre"}, 64'(ready_a), 64'(1));
    data_a  = d;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
  endtask

  task automatic frame_a(input string tag, input logic [7:0] d, input logic p);
    logic [43:0] w;
    int dc, dn, bc, rl;
    send_a(tag, d);
    capture_a(w, dc, dn, bc, rl);
    check({tag, "_wave"},     64'(w),  64'(exp_wave(d, p)));
    check({tag, "_parity"},   64'(w[39:36]), 64'({4{p}}));
    check({tag, "_done_cyc"}, 64'(dc), 64'(44));
    check({tag, "_done_cnt"}, 64'(dn), 64'(1));
    check({tag, "_busy_cnt"}, 64'(bc), 64'(44));
    @(negedge clk);
    check({tag, "_idle_tx"},   64'(tx_a),    64'(1));
    check({tag, "_idle_busy"}, 64'(busy_a),  64'(0));
    check({tag, "_idle_rdy"},  64'(ready_a), 64'(1));
  endtask

  initial begin
    logic [43:0] w;
    logic [15:0] wb;
    int dc, dn, bc, rl;

    reset_n = 1'b0;
    data_a = '0; valid_a = 1'b0;
    data_b = '0; valid_b = 1'b0;

    // Reset state
    #12;
    check("rst_tx",    64'(tx_a),    64'(1));
    check("rst_ready", 64'(ready_a), 64'(1));
    check("rst_busy",  64'(busy_a),  64'(0));
    check("rst_done",  64'(done_a),  64'(0));
    check("rst_b_tx",  64'(tx_b),    64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: A5 full frame; 2: 01 parity
    frame_a("t1_a5", 8'hA5, PAR_A5);
    frame_a("t2_01", 8'h01, PAR_01);

    // 3: back-to-back with data_valid held high
    @(negedge clk);
    data_a  = 8'h3C;
    valid_a = 1'b1;
    @(posedge clk);
    #1 data_a = 8'hC3;
    capture_a(w, dc, dn, bc, rl);
    check("t3_f1_wave",   64'(w),  64'(exp_wave(8'h3C, PAR_3C)));
    check("t3_f1_rdylow", 64'(rl), 64'(44));
    check("t3_f1_done",   64'(dc), 64'(44));
    @(negedge clk);
    check("t3_gap_tx",  64'(tx_a),    64'(1));
    check("t3_gap_rdy", 64'(ready_a), 64'(1));
    @(posedge clk);
    #1 valid_a = 1'b0;
    capture_a(w, dc, dn, bc, rl);
    check("t3_f2_wave",   64'(w),  64'(exp_wave(8'hC3, PAR_C3)));
    check("t3_f2_parity", 64'(w[39:36]), 64'({4{PAR_C3}}));
    check("t3_f2_rdylow", 64'(rl), 64'(44));

    // 4: data_in change and data_valid pulse mid-frame are ignored
    send_a("t4", 8'h96);
    fork
      capture_a(w, dc, dn, bc, rl);
      begin
        repeat (10) @(negedge clk);
        data_a  = 8'hFF;
        valid_a = 1'b1;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
      end
    join
    check("t4_wave",   64'(w),  64'(exp_wave(8'h96, PAR_96)));
    check("t4_rdylow", 64'(rl), 64'(44));
    check("t4_done",   64'(dn), 64'(1));
    repeat (2) @(negedge clk);
    check("t4_no_extra_busy", 64'(busy_a), 64'(0));
    check("t4_no_extra_tx",   64'(tx_a),   64'(1));

    // 5: reset during DATA bit 3 (cycles 17..20 after accept)
    send_a("t5", 8'h00);
    repeat (18) @(negedge clk);
    check("t5_pre_tx",   64'(tx_a),   64'(0));
    check("t5_pre_busy", 64'(busy_a), 64'(1));
    reset_n = 1'b0;
    #1;
    check("t5_async_tx",   64'(tx_a),    64'(1));
    check("t5_async_rdy",  64'(ready_a), 64'(1));
    check("t5_async_busy", 64'(busy_a),  64'(0));
    dn = 0;
    bc = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    reset_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (done_a) dn++;
      if (busy_a) bc++;
    end
    check("t5_no_done", 64'(dn), 64'(0));
    check("t5_no_busy", 64'(bc), 64'(0));
    frame_a("t5_after", 8'hA5, PAR_A5);

    // 6: DATA_W=5, CLKS_PER_BIT=2, 5'h1F -> 16-cycle frame
    @(negedge clk);
    check("t6_ready_pre", 64'(ready_b), 64'(1));
    data_b  = 5'h1F;
    valid_b = 1'b1;
    @(posedge clk);
    #1 valid_b = 1'b0;
    wb = '0; dc = 0; dn = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      wb[c] = tx_b;
      if (done_b) begin dn++; dc = c + 1; end
    end
    check("t6_wave",     64'(wb), 64'({2'b11, {2{PAR_1F}}, 10'h3FF, 2'b00}));
    check("t6_done_cyc", 64'(dc), 64'(16));
    check("t6_done_cnt", 64'(dn), 64'(1));
    @(negedge clk);
    check("t6_idle_busy", 64'(busy_b), 64'(0));
    check("t6_idle_tx",   64'(tx_b),   64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
